calc_entry_fsm: RTL and testbench
=================================

Name: calc_entry_fsm

Overview:
- Sits directly downstream of the keypad scanner and consumes its numberflag/key_value, opflag/operator and equal outputs.
- Assembles two multi-digit decimal operands and one operator code from the keypress stream.
- On "=" it presents {op_a, alu_op, op_b} to the arithmetic unit through a valid/ready handshake.
- Drives disp_value, the operand currently being edited, for the display path.

Parameters:
- WIDTH, 16, operand width in bits.
- MAX_DIGITS, 4, maximum decimal digits per operand; 10^MAX_DIGITS-1 must be < 2^WIDTH.

Ports:
- clk  input  1  system clock (same clock as keypad scanner)
- RST  input  1  asynchronous active-low reset
- numberflag  input  1  level, high while a digit key is held
- key_value  input  4  digit value, valid while numberflag high
- opflag  input  1  level, high while an operator key is held
- operator  input  3  operator code, valid while opflag high
- equal  input  1  level, high while "=" is held
- op_a  output  WIDTH  first operand (binary)
- op_b  output  WIDTH  second operand (binary)
- alu_op  output  3  captured operator code
- exec_valid  output  1  request to arithmetic unit
- exec_ready  input  1  arithmetic unit accepts request
- disp_value  output  WIDTH  operand being edited
- digit_ovf  output  1  sticky: a digit was dropped because the operand was full

Behaviour:
- Reset (RST low, asynchronous) clears everything:
  - state=S_A; op_a=op_b=0; alu_op=0; exec_valid=0; digit_ovf=0; digit counter=0; edge registers=0.
- Edge detection:
  - numberflag, opflag and equal are levels held until key release; each is registered (x_q).
  - An event is x & ~x_q, so one event per keypress.
  - Latency: the action takes effect at the first clk rising edge that samples x=1 with x_q=0.
- Event priority if several rise in the same cycle: equal > op > digit.
- Digit event:
  - key_value>9 is ignored.
  - If digit counter < MAX_DIGITS: operand = operand*10 + key_value, computed as (operand<<3)+(operand<<1)+digit truncated to WIDTH; counter+1.
  - Otherwise the operand is unchanged and digit_ovf is set.
- States:
  - S_A (entering op_a):
    - digit -> accumulate into op_a.
    - op (operator!=0) -> alu_op=operator, counter=0, op_b=0, go S_B. Accepted with zero digits; op_a is then 0.
    - equal -> ignored.
  - S_B (entering op_b):
    - op with counter==0 -> alu_op replaced by the new operator.
    - op with counter>0 -> ignored; no chaining.
    - digit -> accumulate into op_b.
    - equal with counter>0 -> exec_valid=1, go S_EXEC.
    - equal with counter==0 -> ignored.
  - S_EXEC:
    - exec_valid stays high and op_a/op_b/alu_op stay stable until exec_ready is sampled high.
    - On that edge: exec_valid=0, go S_DONE.
    - exec_ready high in the same cycle exec_valid rises is not possible (valid is registered).
    - All key events in this state are ignored.
  - S_DONE:
    - digit -> op_a=digit, op_b=0, counter=1, digit_ovf=0, go S_A.
    - op -> keep op_a, alu_op=operator, op_b=0, counter=0, go S_B.
    - equal -> ignored.
- Operator code 000 is ignored in every state.
- disp_value: op_a in S_A; op_b in S_B, S_EXEC and S_DONE, except op_a in S_B while counter==0.
- digit_ovf clears on entry to S_A from S_DONE and on reset.
- Reset mid-operation, including with exec_valid high: immediate return to reset values; the arithmetic unit must tolerate a withdrawn request.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package calc_pkg holds:
  - operator codes: OP_ADD=3'b001, OP_SUB=3'b010, OP_MUL=3'b011, OP_DIV=3'b100, OP_MOD=3'b101, OP_NONE=3'b000;
  - state encoding S_A, S_B, S_EXEC, S_DONE.
- One natural sub-module: bcd_accum. It holds the WIDTH-bit operand, the digit counter, the x10+d datapath and overflow detection, and is instantiated once with a select between op_a and op_b. Alternatively it is instantiated twice, with the FSM choosing which one is enabled.

Test Plan:
- Reset, then key pulses 1,2,+,3,4,= with exec_ready tied high -> op_a=12, alu_op=001, op_b=34, exec_valid high for exactly 1 cycle, state S_DONE.
- Hold numberflag high 20 cycles with key_value=7 -> op_a=7; exactly one digit accepted.
- Digits 9,8,7,6,5 in S_A -> op_a=9876, digit_ovf=1, disp_value=9876.
- 5, -, * (operator 011), 2, = -> alu_op=011, op_b=2. Then a further operator press before "=" in the next operand with digits present -> ignored.
- Hold exec_ready low 10 cycles after "=", pressing digit 4 meanwhile -> exec_valid held, operands unchanged; it drops one edge after exec_ready rises.
- Assert RST mid-S_EXEC -> exec_valid=0, op_a=op_b=0, alu_op=0, state S_A. Then from S_DONE, press digit 3 -> op_a=3, op_b=0, digit_ovf=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry path: operator codes and FSM states.
package calc_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_MOD  = 3'b101;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/calc_entry_fsm_if.sv
// Keypad-side inputs and arithmetic-unit request bus of the entry FSM.
interface calc_entry_fsm_if #(
    parameter int WIDTH = 16
);
    logic             numberflag;
    logic [3:0]       key_value;
    logic             opflag;
    logic [2:0]       operator;
    logic             equal;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       alu_op;
    logic             exec_valid;
    logic             exec_ready;
    logic [WIDTH-1:0] disp_value;
    logic             digit_ovf;

    // master is the entry FSM; slave is the keypad/ALU side.
    modport master (
        input  numberflag, key_value, opflag, operator, equal, exec_ready,
        output op_a, op_b, alu_op, exec_valid, disp_value, digit_ovf
    );

    modport slave (
        output numberflag, key_value, opflag, operator, equal, exec_ready,
        input  op_a, op_b, alu_op, exec_valid, disp_value, digit_ovf
    );
endinterface

// File: rtl/calc_entry_fsm_bcd_accum.sv
// One decimal operand: value register, digit counter and x10+d accumulation.
module bcd_accum #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             clr,
    input  logic             load,
    input  logic             add,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic             empty,
    output logic             full
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [CW-1:0] cnt;

    function automatic logic [WIDTH-1:0] mul10_add(input logic [WIDTH-1:0] v,
                                                   input logic [3:0]       d);
        return (v << 3) + (v << 1) + {{(WIDTH-4){1'b0}}, d};
    endfunction

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            value <= '0;
            cnt   <= '0;
        end else if (clr) begin
            value <= '0;
            cnt   <= '0;
        end else if (load) begin
            value <= {{(WIDTH-4){1'b0}}, digit};
            cnt   <= CW'(1);
        end else if (add && !full) begin
            value <= mul10_add(value, digit);
            cnt   <= cnt + CW'(1);
        end
    end

    assign empty = (cnt == '0);
    assign full  = (int'(cnt) >= MAX_DIGITS);

endmodule

// File: rtl/calc_entry_fsm.sv
// Keypress-to-operand entry FSM: builds op_a, operator, op_b and hands them to the ALU.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input logic            clk,
    input logic            RST,
    calc_entry_fsm_if.master bus
);
    state_t           state, state_d;
    logic             num_q, op_q, eq_q;
    logic [2:0]       alu_op_r, alu_d;
    logic             valid_r, valid_d;
    logic             ovf_r, ovf_d;
    logic             a_add, a_load, b_add, b_clr;
    logic [WIDTH-1:0] a_val, b_val, disp;
    logic             a_full, a_empty_unused, b_full, b_empty;
    logic             num_ev, op_ev, eq_ev, dig_ok, op_ok;

    bcd_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk(clk), .RST(RST), .clr(1'b0), .load(a_load), .add(a_add),
        .digit(bus.key_value), .value(a_val), .empty(a_empty_unused), .full(a_full)
    );

    bcd_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk(clk), .RST(RST), .clr(b_clr), .load(1'b0), .add(b_add),
        .digit(bus.key_value), .value(b_val), .empty(b_empty), .full(b_full)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state    <= S_A;
            num_q    <= 1'b0;
            op_q     <= 1'b0;
            eq_q     <= 1'b0;
            alu_op_r <= OP_NONE;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state    <= state_d;
            num_q    <= bus.numberflag;
            op_q     <= bus.opflag;
            eq_q     <= bus.equal;
            alu_op_r <= alu_d;
            valid_r  <= valid_d;
            ovf_r    <= ovf_d;
        end
    end

    // One event per keypress; equal outranks op, op outranks digit.
    assign num_ev = bus.numberflag & ~num_q;
    assign op_ev  = bus.opflag & ~op_q;
    assign eq_ev  = bus.equal & ~eq_q;
    assign dig_ok = (bus.key_value <= 4'd9);
    assign op_ok  = (bus.operator != OP_NONE);

    always_comb begin
        state_d = state;
        alu_d   = alu_op_r;
        valid_d = valid_r;
        ovf_d   = ovf_r;
        a_add   = 1'b0;
        a_load  = 1'b0;
        b_add   = 1'b0;
        b_clr   = 1'b0;
        unique case (state)
            S_A: begin
                if (!eq_ev) begin
                    if (op_ev) begin
                        if (op_ok) begin
                            alu_d   = bus.operator;
                            b_clr   = 1'b1;
                            state_d = S_B;
                        end
                    end else if (num_ev && dig_ok) begin
                        if (a_full) ovf_d = 1'b1;
                        else        a_add = 1'b1;
                    end
                end
            end
            S_B: begin
                if (eq_ev) begin
                    if (!b_empty) begin
                        valid_d = 1'b1;
                        state_d = S_EXEC;
                    end
                end else if (op_ev) begin
                    if (op_ok && b_empty) alu_d = bus.operator;
                end else if (num_ev && dig_ok) begin
                    if (b_full) ovf_d = 1'b1;
                    else        b_add = 1'b1;
                end
            end
            S_EXEC: begin
                if (bus.exec_ready) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!eq_ev) begin
                    if (op_ev) begin
                        if (op_ok) begin
                            alu_d   = bus.operator;
                            b_clr   = 1'b1;
                            state_d = S_B;
                        end
                    end else if (num_ev && dig_ok) begin
                        a_load  = 1'b1;
                        b_clr   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = S_A;
                    end
                end
            end
            default: state_d = S_A;
        endcase
    end

    // Show op_a until the first digit of op_b arrives.
    always_comb begin
        disp = b_val;
        if (state == S_A || (state == S_B && b_empty)) disp = a_val;
    end

    assign bus.op_a       = a_val;
    assign bus.op_b       = b_val;
    assign bus.alu_op     = alu_op_r;
    assign bus.exec_valid = valid_r;
    assign bus.disp_value = disp;
    assign bus.digit_ovf  = ovf_r;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: vector table, corner sequences and random keypresses vs a digit-list model.
module tb_calc_entry_fsm;
    import calc_pkg::*;

    localparam int WIDTH = 16;
    localparam int MAXD  = 4;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    calc_entry_fsm_if #(.WIDTH(WIDTH)) bus();

    calc_entry_fsm #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
        .clk(clk),
        .RST(RST),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cycles;

    // Reference model: operands kept as lists of entered decimal digits.
    int m_phase;          // 0 first operand, 1 second operand, 2 awaiting ALU, 3 result shown
    int m_a[$];
    int m_b[$];
    int m_alu;
    bit m_valid, m_ovf;
    bit p_nf, p_of, p_eq;

    function automatic int num_of(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v % (1 << WIDTH);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_a = {}; m_b = {}; m_alu = 0;
        m_valid = 0; m_ovf = 0; p_nf = 0; p_of = 0; p_eq = 0;
    endtask

    task automatic model_step();
        bit en, eo, ee, dok, ook;
        int kv;
        en = bus.numberflag && !p_nf;
        eo = bus.opflag && !p_of;
        ee = bus.equal && !p_eq;
        p_nf = bus.numberflag; p_of = bus.opflag; p_eq = bus.equal;
        kv  = int'(bus.key_value);
        dok = (kv <= 9);
        ook = (bus.operator != 3'd0);
        case (m_phase)
            0: if (!ee) begin
                if (eo) begin
                    if (ook) begin m_alu = int'(bus.operator); m_b = {}; m_phase = 1; end
                end else if (en && dok) begin
                    if (m_a.size() < MAXD) m_a.push_back(kv); else m_ovf = 1;
                end
            end
            1: if (ee) begin
                if (m_b.size() > 0) begin m_valid = 1; m_phase = 2; end
            end else if (eo) begin
                if (ook && m_b.size() == 0) m_alu = int'(bus.operator);
            end else if (en && dok) begin
                if (m_b.size() < MAXD) m_b.push_back(kv); else m_ovf = 1;
            end
            2: if (bus.exec_ready) begin m_valid = 0; m_phase = 3; end
            default: if (!ee) begin
                if (eo) begin
                    if (ook) begin m_alu = int'(bus.operator); m_b = {}; m_phase = 1; end
                end else if (en && dok) begin
                    m_a = {kv}; m_b = {}; m_ovf = 0; m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int exp_disp;
        exp_disp = (m_phase == 0 || (m_phase == 1 && m_b.size() == 0)) ? num_of(m_a) : num_of(m_b);
        check({tag, "_op_a"}, 32'(bus.op_a), num_of(m_a));
        check({tag, "_op_b"}, 32'(bus.op_b), num_of(m_b));
        check({tag, "_alu_op"}, 32'(bus.alu_op), m_alu);
        check({tag, "_exec_valid"}, 32'(bus.exec_valid), 32'(m_valid));
        check({tag, "_digit_ovf"}, 32'(bus.digit_ovf), 32'(m_ovf));
        check({tag, "_disp"}, 32'(bus.disp_value), exp_disp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (RST) model_step(); else model_reset();
        @(negedge clk);
        check_outputs("model");
        if (bus.exec_valid) valid_cycles++;
    endtask

    task automatic release_keys();
        bus.numberflag = 0; bus.opflag = 0; bus.equal = 0;
    endtask

    // kind: 0 digit, 1 operator, 2 equal
    task automatic press(input int kind, input int val);
        case (kind)
            0: begin bus.numberflag = 1; bus.key_value = 4'(val); end
            1: begin bus.opflag = 1; bus.operator = 3'(val); end
            default: bus.equal = 1;
        endcase
        repeat (2) tick();
        release_keys();
        repeat (2) tick();
    endtask

    task automatic do_reset();
        release_keys();
        bus.key_value = 0; bus.operator = 0;
        RST = 0;
        model_reset();
        repeat (2) tick();
        RST = 1;
        tick();
    endtask

    typedef struct {
        int kind; int val;
        int a; int b; int alu; int disp; int ovf; int vcyc;
    } vec_t;
    vec_t tbl[$];

    initial begin
        RST = 0;
        bus.exec_ready = 1;
        release_keys();
        bus.key_value = 0; bus.operator = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("reset_op_a", 32'(bus.op_a), 0);
        check("reset_op_b", 32'(bus.op_b), 0);
        check("reset_alu_op", 32'(bus.alu_op), 0);
        check("reset_exec_valid", 32'(bus.exec_valid), 0);
        check("reset_digit_ovf", 32'(bus.digit_ovf), 0);

        //                kind val    a     b   alu  disp ovf vcyc
        tbl.push_back('{0, 1,     1,    0,  0,    1,  0, 0});
        tbl.push_back('{0, 2,    12,    0,  0,   12,  0, 0});
        tbl.push_back('{1, 1,    12,    0,  1,   12,  0, 0});
        tbl.push_back('{0, 3,    12,    3,  1,    3,  0, 0});
        tbl.push_back('{0, 4,    12,   34,  1,   34,  0, 0});
        tbl.push_back('{2, 0,    12,   34,  1,   34,  0, 1});
        tbl.push_back('{0, 9,     9,    0,  1,    9,  0, 0});
        tbl.push_back('{0, 8,    98,    0,  1,   98,  0, 0});
        tbl.push_back('{0, 7,   987,    0,  1,  987,  0, 0});
        tbl.push_back('{0, 6,  9876,    0,  1, 9876,  0, 0});
        tbl.push_back('{0, 5,  9876,    0,  1, 9876,  1, 0});
        tbl.push_back('{1, 2,  9876,    0,  2, 9876,  1, 0});
        tbl.push_back('{1, 3,  9876,    0,  3, 9876,  1, 0});
        tbl.push_back('{1, 0,  9876,    0,  3, 9876,  1, 0});
        tbl.push_back('{0, 2,  9876,    2,  3,    2,  1, 0});
        tbl.push_back('{1, 1,  9876,    2,  3,    2,  1, 0});
        tbl.push_back('{2, 0,  9876,    2,  3,    2,  1, 1});
        tbl.push_back('{0, 5,     5,    0,  3,    5,  0, 0});
        tbl.push_back('{2, 0,     5,    0,  3,    5,  0, 0});
        tbl.push_back('{0, 12,    5,    0,  3,    5,  0, 0});
        tbl.push_back('{1, 4,     5,    0,  4,    5,  0, 0});
        tbl.push_back('{2, 0,     5,    0,  4,    5,  0, 0});

        foreach (tbl[i]) begin
            valid_cycles = 0;
            press(tbl[i].kind, tbl[i].val);
            check($sformatf("tbl%0d_op_a", i), 32'(bus.op_a), tbl[i].a);
            check($sformatf("tbl%0d_op_b", i), 32'(bus.op_b), tbl[i].b);
            check($sformatf("tbl%0d_alu_op", i), 32'(bus.alu_op), tbl[i].alu);
            check($sformatf("tbl%0d_disp", i), 32'(bus.disp_value), tbl[i].disp);
            check($sformatf("tbl%0d_ovf", i), 32'(bus.digit_ovf), tbl[i].ovf);
            check($sformatf("tbl%0d_valid_cycles", i), 32'(valid_cycles), tbl[i].vcyc);
        end

        // A held digit key counts once.
        do_reset();
        bus.numberflag = 1; bus.key_value = 7;
        repeat (20) tick();
        release_keys();
        tick();
        check("hold_op_a", 32'(bus.op_a), 7);

        // Request held while the ALU stalls; key presses in the meantime are ignored.
        do_reset();
        bus.exec_ready = 0;
        press(0, 1); press(1, OP_ADD); press(0, 2); press(2, 0);
        bus.numberflag = 1; bus.key_value = 4;
        repeat (10) tick();
        release_keys();
        check("stall_valid", 32'(bus.exec_valid), 1);
        check("stall_op_a", 32'(bus.op_a), 1);
        check("stall_op_b", 32'(bus.op_b), 2);
        check("stall_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
        bus.exec_ready = 1;
        tick();
        check("stall_drop", 32'(bus.exec_valid), 0);

        // Asynchronous reset while the request is pending.
        do_reset();
        bus.exec_ready = 0;
        press(0, 3); press(1, OP_SUB); press(0, 4); press(2, 0);
        check("pre_rst_valid", 32'(bus.exec_valid), 1);
        #2 RST = 0;
        #1 model_reset();
        check("async_valid", 32'(bus.exec_valid), 0);
        check("async_op_a", 32'(bus.op_a), 0);
        check("async_op_b", 32'(bus.op_b), 0);
        check("async_alu_op", 32'(bus.alu_op), 0);
        tick();
        RST = 1;
        bus.exec_ready = 1;
        tick();
        press(0, 6);
        check("after_rst_op_a", 32'(bus.op_a), 6);

        // Overflowed operand, full round trip, then a new digit from the result state.
        do_reset();
        for (int i = 0; i < 5; i++) press(0, 1);
        check("ovf_set", 32'(bus.digit_ovf), 1);
        press(1, OP_MUL); press(0, 1); press(2, 0);
        press(0, 3);
        check("done_digit_op_a", 32'(bus.op_a), 3);
        check("done_digit_op_b", 32'(bus.op_b), 0);
        check("done_digit_ovf", 32'(bus.digit_ovf), 0);

        // Random keypress traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.numberflag = ~bus.numberflag;
            if ($urandom_range(0, 5) == 0) bus.opflag = ~bus.opflag;
            if ($urandom_range(0, 7) == 0) bus.equal = ~bus.equal;
            if (!bus.numberflag) bus.key_value = 4'($urandom_range(0, 11));
            if (!bus.opflag) bus.operator = 3'($urandom_range(0, 5));
            bus.exec_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
